// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave, MSB first, oversampled by clk so received bytes land directly in the clk domain.
// Optional frame_err output is built when SPI_SLAVE_SYNC_FRAME_ERR_EN is defined.
module spi_slave_sync #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                    sclk_dly_q, cs_dly_q;
  logic [DATA_WIDTH-1:0]   tx_sr_q, dout_q;
  logic [DATA_WIDTH-2:0]   rx_sr_q;
  logic [CntW-1:0]         bit_cnt_q;
  logic                    dout_valid_q;
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
  logic                    frame_err_q;
`endif

  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DATA_WIDTH-1:0]   rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign rx_next   = {rx_sr_q, mosi_s};

  // tx_sr is cleared outside a frame, so its MSB is directly the idle-low miso.
  assign miso       = tx_sr_q[DATA_WIDTH-1];
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == StShift);
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
  assign frame_err  = frame_err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // cs history resets low: a cs already low at release must not look like a falling edge.
      sclk_sync_q  <= '0;
      cs_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sclk_dly_q   <= 1'b0;
      cs_dly_q     <= 1'b0;
      state_q      <= StIdle;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_dly_q   <= sclk_s;
      cs_dly_q     <= cs_s;
      dout_valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StShift;
            tx_sr_q   <= din;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
            frame_err_q <= sclk_s;
`endif
          end
        end
        StShift: begin
          if (cs_rise) begin
            state_q   <= StIdle;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
            if (bit_cnt_q != '0) frame_err_q <= 1'b1;
`endif
          end else if (sclk_rise) begin
            rx_sr_q <= rx_next[DATA_WIDTH-2:0];
            if (bit_cnt_q == LastBit) begin
              dout_q       <= rx_next;
              dout_valid_q <= 1'b1;
              bit_cnt_q    <= '0;
              tx_sr_q      <= din;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end else if (sclk_fall && (bit_cnt_q != '0)) begin
            // No shift right after a byte boundary, or the reloaded MSB would be skipped.
            tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a mode-0 master model drives sclk/cs/mosi with a random
// clk phase offset and checks both received directions plus reset and abort behaviour.
module tb_spi_slave_sync;
  localparam int unsigned W    = 8;
  localparam int unsigned HALF = 50;  // sclk phase in ns: 5 clk cycles = SYNC_STAGES+3

  logic         clk = 1'b0;
  logic         reset, sclk, cs, mosi, miso, dout_valid, busy;
  logic [W-1:0] din, dout;
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
  logic         frame_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] got_q[$];

  always #5 clk = ~clk;

  spi_slave_sync #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy)
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  // One entry per clk cycle that dout_valid is high, so a stretched pulse shows up as extras.
  always @(negedge clk) if (reset && dout_valid) got_q.push_back(dout);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Master edges land 1..9 ns after a posedge, never on one.
  task automatic align();
    int unsigned o;
    o = $urandom_range(1, 8);
    if (o >= 5) o++;
    @(posedge clk);
    #(o);
  endtask

  task automatic cs_low();
    align();
    cs = 1'b0;
    #(2 * HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    cs = 1'b1;
    #(2 * HALF);
  endtask

  // Shifts nbits of tx MSB first; miso is sampled at each rising edge. next_din is applied
  // after the last falling edge, i.e. it is what the boundary after the following byte loads.
  task automatic xfer(input logic [W-1:0] tx, input int nbits, input logic [W-1:0] next_din,
                      output logic [W-1:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[W-1-i];
      #(HALF);
      sclk = 1'b1;
      rx   = {rx[W-2:0], miso};
      #(HALF);
      sclk = 1'b0;
    end
    din = next_din;
  endtask

  initial begin
    logic [W-1:0] rx0, rx1;
    logic [W-1:0] tx_b[8];
    logic [W-1:0] sx_b[8];

    reset = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; din = 8'hA5;
    repeat (4) @(negedge clk);
    check_eq("rst_miso", miso, 1'b0);
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_valid", dout_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
    check_eq("rst_ferr", frame_err, 1'b0);
`endif
    reset = 1'b1;
    repeat (6) @(negedge clk);

    // Single byte: slave sends 0xA5, master sends 0x3C.
    cs_low();
    check_eq("b1_busy_hi", busy, 1'b1);
    xfer(8'h3C, 8, 8'hA5, rx0);
    cs_high();
    check_eq("b1_miso_rx", rx0, 8'hA5);
    check_eq("b1_npulse", got_q.size(), 1);
    if (got_q.size() >= 1) check_eq("b1_pulse_dat", got_q[0], 8'h3C);
    check_eq("b1_dout", dout, 8'h3C);
    check_eq("b1_busy_lo", busy, 1'b0);
    check_eq("b1_miso_idle", miso, 1'b0);
    got_q.delete();

    // Back-to-back: the second byte's din must be present before the first byte boundary,
    // because the reload happens on the same clk as the first dout_valid.
    din = 8'h96;
    cs_low();
    din = 8'hFF;
    xfer(8'h01, 8, 8'hFF, rx0);
    xfer(8'h80, 8, 8'h00, rx1);
    cs_high();
    check_eq("b2_miso_rx0", rx0, 8'h96);
    check_eq("b2_miso_rx1", rx1, 8'hFF);
    check_eq("b2_npulse", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check_eq("b2_pulse0", got_q[0], 8'h01);
      check_eq("b2_pulse1", got_q[1], 8'h80);
    end
    check_eq("b2_dout", dout, 8'h80);
    got_q.delete();

    // Abort after 5 bits of 0xF0.
    din = 8'h00;
    cs_low();
    xfer(8'hF0, 5, 8'h00, rx0);
    cs_high();
    check_eq("ab_npulse", got_q.size(), 0);
    check_eq("ab_dout", dout, 8'h80);
    check_eq("ab_busy", busy, 1'b0);
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
    check_eq("ab_ferr_set", frame_err, 1'b1);
`endif
    din = 8'h69;
    cs_low();
`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
    check_eq("ab_ferr_clr", frame_err, 1'b0);
`endif
    xfer(8'hC3, 8, 8'h00, rx0);
    cs_high();
    check_eq("ab_next_rx", rx0, 8'h69);
    check_eq("ab_next_dout", dout, 8'hC3);
    got_q.delete();

`ifdef SPI_SLAVE_SYNC_FRAME_ERR_EN
    // sclk high when cs falls means the master is not in mode 0.
    align();
    sclk = 1'b1;
    #(HALF);
    cs = 1'b0;
    #(2 * HALF);
    check_eq("m0_ferr", frame_err, 1'b1);
    sclk = 1'b0;
    cs_high();
`endif

    // Reset mid-frame after 3 bits, cs held low through and after reset.
    din = 8'hE7;
    cs_low();
    xfer(8'hAA, 3, 8'h00, rx0);
    #7;
    reset = 1'b0;
    #2;
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_dout", dout, 8'h00);
    check_eq("mr_valid", dout_valid, 1'b0);
    check_eq("mr_miso", miso, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    xfer(8'hFF, 8, 8'h00, rx0);
    #(HALF);
    check_eq("mr_stay_idle", busy, 1'b0);
    check_eq("mr_no_miso", rx0, 8'h00);
    check_eq("mr_npulse0", got_q.size(), 0);
    check_eq("mr_dout_hold", dout, 8'h00);
    cs = 1'b1;
    #(2 * HALF);
    din = 8'h33;
    cs_low();
    xfer(8'h5A, 8, 8'h00, rx0);
    cs_high();
    check_eq("mr_rx", rx0, 8'h33);
    check_eq("mr_npulse1", got_q.size(), 1);
    check_eq("mr_dout", dout, 8'h5A);
    got_q.delete();

    // Minimum phase length with random offset: 50 frames of 8 back-to-back bytes.
    for (int f = 0; f < 50; f++) begin
      for (int b = 0; b < 8; b++) begin
        tx_b[b] = W'($urandom);
        sx_b[b] = W'($urandom);
      end
      din = sx_b[0];
      cs_low();
      din = sx_b[1];
      for (int b = 0; b < 8; b++) begin
        xfer(tx_b[b], 8, (b < 6) ? sx_b[b+2] : 8'h00, rx0);
        check_eq("st_miso", rx0, sx_b[b]);
      end
      cs_high();
      check_eq("st_npulse", got_q.size(), 8);
      for (int b = 0; b < 8; b++) begin
        if (b < got_q.size()) check_eq("st_mosi", got_q[b], tx_b[b]);
      end
      got_q.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
